// File: rtl/tetris_pkg.sv
// Shared board constants, cell/shape types, commit FSM states and line-score table
// for the tetris playfield blocks.
package tetris_pkg;

  localparam int BOARD_W_DEFAULT = 20;
  localparam int BOARD_H_DEFAULT = 30;

  typedef logic [2:0] shape_t;

  localparam logic [2:0] CELL_EMPTY = 3'd0;

  // Points awarded for 0..4 rows completed by a single piece
  localparam logic [15:0] LINE_SCORE [5] = '{16'd0, 16'd40, 16'd100, 16'd300, 16'd1200};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } commit_state_e;

  function automatic logic [15:0] line_score(input logic [2:0] n_rows);
    logic [15:0] pts;
    case (n_rows)
      3'd0:    pts = LINE_SCORE[0];
      3'd1:    pts = LINE_SCORE[1];
      3'd2:    pts = LINE_SCORE[2];
      3'd3:    pts = LINE_SCORE[3];
      3'd4:    pts = LINE_SCORE[4];
      default: pts = 16'd0;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/piece_commit_row_full_checker.sv
// AND-accumulates "cell occupied" across one streamed board row; full_o is valid
// only in the cycle that carries the last cell of the row.
module row_full_checker
  import tetris_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] data_i,
  input  logic       valid_i,
  input  logic       first_i,
  input  logic       last_i,
  output logic       full_o
);

  logic acc_q;
  logic nz;

  assign nz = (data_i != CELL_EMPTY);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= 1'b0;
    end else if (valid_i) begin
      acc_q <= first_i ? nz : (acc_q & nz);
    end
  end

  assign full_o = valid_i & last_i & nz & (first_i | acc_q);

endmodule

// File: rtl/piece_commit.sv
// Writes a landed piece's four cells to the board RAM, then rescans each distinct
// touched row and reports which are full. Optional scorer: PIECE_COMMIT_SCORE_EN.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; results from the last commit held
//   ST_WRITE | one RAM write per cycle, cells 0..3
//   ST_SCAN  | stream row y[r] through the checker, BOARD_W+1 cycles per row
//   ST_DONE  | one-cycle done pulse, busy already low
module piece_commit
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [2:0]  shape,
  input  logic [4:0]  x0,
  input  logic [4:0]  x1,
  input  logic [4:0]  x2,
  input  logic [4:0]  x3,
  input  logic [5:0]  y0,
  input  logic [5:0]  y1,
  input  logic [5:0]  y2,
  input  logic [5:0]  y3,
  output logic        busy,
  output logic        wr_en,
  output logic [4:0]  wr_x,
  output logic [5:0]  wr_y,
  output logic [2:0]  wr_data,
  output logic [4:0]  rd_x,
  output logic [5:0]  rd_y,
  input  logic [2:0]  rd_data,
  output logic        done,
  output logic [3:0]  full_mask,
`ifdef PIECE_COMMIT_SCORE_EN
  input  logic        score_clr,
  output logic [15:0] score,
`endif
  output logic [2:0]  full_count
);

  localparam logic [5:0] LAST_CNT = 6'(BOARD_W);

  commit_state_e state_q, state_d;

  shape_t      shape_q;
  logic [4:0]  x_q [4];
  logic [5:0]  y_q [4];
  logic [1:0]  k_q;
  logic [1:0]  r_q;
  logic [5:0]  cnt_q;
  logic [4:0]  rd_x_q;
  logic [5:0]  rd_y_q;
  logic [3:0]  full_mask_q;
  logic [2:0]  full_count_q;

  logic [3:0]  dup;
  logic        nxt_valid;
  logic [1:0]  nxt_r;
  logic        row_full;
  logic        chk_valid;
  logic        row_end;

  // A row already seen at a lower index is not scanned again
  always_comb begin
    dup    = 4'b0000;
    dup[1] = (y_q[1] == y_q[0]);
    dup[2] = (y_q[2] == y_q[0]) || (y_q[2] == y_q[1]);
    dup[3] = (y_q[3] == y_q[0]) || (y_q[3] == y_q[1]) || (y_q[3] == y_q[2]);
  end

  always_comb begin
    nxt_valid = 1'b0;
    nxt_r     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((2'(i) > r_q) && !dup[i]) begin
        nxt_valid = 1'b1;
        nxt_r     = 2'(i);
      end
    end
  end

  assign row_end   = (state_q == ST_SCAN) && (cnt_q == LAST_CNT);
  assign chk_valid = (state_q == ST_SCAN) && (cnt_q != 6'd0);

  row_full_checker u_row_full_checker (
    .clk_i   (Clk),
    .reset_i (Reset),
    .data_i  (rd_data),
    .valid_i (chk_valid),
    .first_i (cnt_q == 6'd1),
    .last_i  (cnt_q == LAST_CNT),
    .full_o  (row_full)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_WRITE;
      ST_WRITE: if (k_q == 2'd3) state_d = ST_SCAN;
      ST_SCAN:  if (row_end && !nxt_valid) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == ST_WRITE) || (state_q == ST_SCAN);
    done    = (state_q == ST_DONE);
    wr_en   = (state_q == ST_WRITE);
    wr_x    = wr_en ? x_q[k_q] : 5'd0;
    wr_y    = wr_en ? y_q[k_q] : 6'd0;
    wr_data = wr_en ? 3'(shape_q + 3'd1) : 3'd0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      shape_q      <= 3'd0;
      x_q          <= '{default: 5'd0};
      y_q          <= '{default: 6'd0};
      k_q          <= 2'd0;
      r_q          <= 2'd0;
      cnt_q        <= 6'd0;
      rd_x_q       <= 5'd0;
      rd_y_q       <= 6'd0;
      full_mask_q  <= 4'b0000;
      full_count_q <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shape_q      <= shape;
            x_q          <= '{x0, x1, x2, x3};
            y_q          <= '{y0, y1, y2, y3};
            k_q          <= 2'd0;
            full_mask_q  <= 4'b0000;
            full_count_q <= 3'd0;
          end
        end
        ST_WRITE: begin
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            r_q    <= 2'd0;
            cnt_q  <= 6'd0;
            rd_x_q <= 5'd0;
            rd_y_q <= y_q[0];
          end
        end
        ST_SCAN: begin
          if (cnt_q == LAST_CNT) begin
            if (row_full) begin
              full_mask_q[r_q] <= 1'b1;
              full_count_q     <= full_count_q + 3'd1;
            end
            if (nxt_valid) begin
              r_q    <= nxt_r;
              cnt_q  <= 6'd0;
              rd_x_q <= 5'd0;
              rd_y_q <= y_q[nxt_r];
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
            // rd_x tracks cnt but parks on the last column during the trailing sample
            if (cnt_q < LAST_CNT - 6'd1) rd_x_q <= rd_x_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign full_mask  = full_mask_q;
  assign full_count = full_count_q;

`ifdef PIECE_COMMIT_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  assign score_sum = {1'b0, score_q} + {1'b0, line_score(full_count_q)};

  always_ff @(posedge Clk) begin
    if (Reset || score_clr) begin
      score_q <= 16'd0;
    end else if (state_q == ST_DONE) begin
      score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_piece_commit.sv
// Directed bench for piece_commit with a behavioural board RAM (one-cycle read latency).
module tb_piece_commit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [2:0]  shape;
  logic [4:0]  x0, x1, x2, x3;
  logic [5:0]  y0, y1, y2, y3;
  logic        busy, wr_en, done;
  logic [4:0]  wr_x, rd_x;
  logic [5:0]  wr_y, rd_y;
  logic [2:0]  wr_data, rd_data;
  logic [3:0]  full_mask;
  logic [2:0]  full_count;
`ifdef PIECE_COMMIT_SCORE_EN
  logic        score_clr;
  logic [15:0] score;
  int          exp_score;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  piece_commit dut (
    .Clk(Clk), .Reset(Reset), .start(start), .shape(shape),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .busy(busy), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .done(done), .full_mask(full_mask),
`ifdef PIECE_COMMIT_SCORE_EN
    .score_clr(score_clr), .score(score),
`endif
    .full_count(full_count)
  );

  // Board RAM model; the bench preloads it through its own write port
  logic [2:0] board [64][32];
  logic       clr;
  logic       tb_we;
  logic [4:0] tb_x;
  logic [5:0] tb_y;

  always @(posedge Clk) begin
    if (clr) begin
      for (int yy = 0; yy < 64; yy++)
        for (int xx = 0; xx < 32; xx++)
          board[yy][xx] <= 3'd0;
    end else begin
      if (tb_we) board[tb_y][tb_x] <= 3'd5;
      if (wr_en) board[wr_y][wr_x] <= wr_data;
    end
    rd_data <= board[rd_y][rd_x];
  end

  // Piece under test and what the commit driver observed
  logic [2:0] pshape;
  int         px [4];
  int         py [4];
  int         wx [4];
  int         wy [4];
  int         wd [4];
  int         nwr, ndone, done_cyc;
  logic       busy_at_done, busy_after;
  logic [3:0] mask_c1;
  logic [2:0] cnt_c1;

  task automatic clear_board();
    @(negedge Clk); clr = 1'b1;
    @(negedge Clk); clr = 1'b0;
  endtask

  // Fill row y with nonzero cells except columns lo..hi
  task automatic fill_row(input int y, input int lo, input int hi);
    for (int x = 0; x < 20; x++) begin
      if (x < lo || x > hi) begin
        @(negedge Clk);
        tb_we = 1'b1; tb_x = 5'(x); tb_y = 6'(y);
      end
    end
    @(negedge Clk); tb_we = 1'b0;
  endtask

  task automatic drive_piece();
    shape = pshape;
    x0 = 5'(px[0]); x1 = 5'(px[1]); x2 = 5'(px[2]); x3 = 5'(px[3]);
    y0 = 6'(py[0]); y1 = 6'(py[1]); y2 = 6'(py[2]); y3 = 6'(py[3]);
  endtask

  // Accepts one piece at cycle 0, observes cycles 1.. until a few cycles past done.
  // extra: cycle in which a second start (with altered coords) is pulsed; hold: keep
  // start high up to and including the done cycle.
  task automatic commit(input int extra, input bit hold);
    @(negedge Clk);
    drive_piece();
    start = 1'b1;
    nwr = 0; ndone = 0; done_cyc = -1;
    busy_at_done = 1'b1; busy_after = 1'b0;
    @(posedge Clk);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge Clk);
      if (cyc == 1) begin mask_c1 = full_mask; cnt_c1 = full_count; end
      if (wr_en) begin
        if (nwr < 4) begin wx[nwr] = wr_x; wy[nwr] = wr_y; wd[nwr] = wr_data; end
        nwr++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
      end else if (done_cyc >= 0 && busy) begin
        busy_after = 1'b1;
      end
      if (cyc + 1 == extra) begin y0 = 6'd3; x0 = 5'd17; end
      start = (cyc + 1 == extra) || (hold && done_cyc < 0);
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    start = 1'b0;
    drive_piece();
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, wr_en, done, wr_x, wr_y, wr_data, rd_x, rd_y, full_mask, full_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b wr_en=%b done=%b wr=%0d/%0d/%0d rd=%0d/%0d mask=%b cnt=%0d want all 0",
               busy, wr_en, done, wr_x, wr_y, wr_data, rd_x, rd_y, full_mask, full_count);
    end
`ifdef PIECE_COMMIT_SCORE_EN
    checks++;
    if (score !== 16'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
`endif
  endtask

  task automatic test_o_empty();
    clear_board();
    pshape = 3'd1;
    px = '{9, 10, 9, 10}; py = '{28, 28, 29, 29};
    commit(-1, 1'b0);
    checks++;
    if (done_cyc !== 47) begin errors++; $display("FAIL o_done_cycle got %0d want 47", done_cyc); end
    checks++;
    if (nwr !== 4) begin errors++; $display("FAIL o_write_count got %0d want 4", nwr); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wx[i] !== px[i] || wy[i] !== py[i] || wd[i] !== 2) begin
        errors++;
        $display("FAIL o_write%0d got x=%0d y=%0d d=%0d want x=%0d y=%0d d=2", i, wx[i], wy[i], wd[i], px[i], py[i]);
      end
    end
    checks++;
    if (full_mask !== 4'b0000 || full_count !== 3'd0) begin
      errors++; $display("FAIL o_result got mask=%b cnt=%0d want mask=0000 cnt=0", full_mask, full_count);
    end
    checks++;
    if (ndone !== 1 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL o_done_pulse got ndone=%0d busy_at_done=%b want 1 and 0", ndone, busy_at_done);
    end
`ifdef PIECE_COMMIT_SCORE_EN
    checks++;
    if (score !== 16'(exp_score)) begin errors++; $display("FAIL o_score got %0d want %0d", score, exp_score); end
`endif
  endtask

  task automatic test_partial_row();
    clear_board();
    fill_row(29, 3, 4);
    fill_row(28, 4, 7);
    pshape = 3'd2;
    px = '{4, 4, 3, 4}; py = '{27, 28, 29, 29};
    commit(-1, 1'b0);
    checks++;
    if (done_cyc !== 68) begin errors++; $display("FAIL partial_done_cycle got %0d want 68", done_cyc); end
    checks++;
    if (full_mask !== 4'b0100 || full_count !== 3'd1) begin
      errors++; $display("FAIL partial_result got mask=%b cnt=%0d want mask=0100 cnt=1", full_mask, full_count);
    end
    checks++;
    if (wd[3] !== 3) begin errors++; $display("FAIL partial_wr_data got %0d want 3", wd[3]); end
`ifdef PIECE_COMMIT_SCORE_EN
    exp_score += 40;
    checks++;
    if (score !== 16'(exp_score)) begin errors++; $display("FAIL partial_score got %0d want %0d", score, exp_score); end
`endif
  endtask

  task automatic test_i_horizontal();
    clear_board();
    fill_row(29, 8, 11);
    pshape = 3'd0;
    px = '{8, 9, 10, 11}; py = '{29, 29, 29, 29};
    commit(-1, 1'b0);
    checks++;
    if (mask_c1 !== 4'b0000 || cnt_c1 !== 3'd0) begin
      errors++; $display("FAIL ih_clear_on_start got mask=%b cnt=%0d want 0000 0", mask_c1, cnt_c1);
    end
    checks++;
    if (done_cyc !== 26) begin errors++; $display("FAIL ih_done_cycle got %0d want 26", done_cyc); end
    checks++;
    if (full_mask !== 4'b0001 || full_count !== 3'd1) begin
      errors++; $display("FAIL ih_result got mask=%b cnt=%0d want mask=0001 cnt=1", full_mask, full_count);
    end
    checks++;
    if (rd_x !== 5'd19 || rd_y !== 6'd29) begin
      errors++; $display("FAIL ih_rd_hold got rd_x=%0d rd_y=%0d want 19 29", rd_x, rd_y);
    end
`ifdef PIECE_COMMIT_SCORE_EN
    exp_score += 40;
    checks++;
    if (score !== 16'(exp_score)) begin errors++; $display("FAIL ih_score got %0d want %0d", score, exp_score); end
`endif
  endtask

  task automatic test_i_vertical();
    clear_board();
    for (int y = 26; y <= 29; y++) fill_row(y, 5, 5);
    pshape = 3'd0;
    px = '{5, 5, 5, 5}; py = '{26, 27, 28, 29};
    commit(-1, 1'b0);
    checks++;
    if (done_cyc !== 89) begin errors++; $display("FAIL iv_done_cycle got %0d want 89", done_cyc); end
    checks++;
    if (full_mask !== 4'b1111 || full_count !== 3'd4) begin
      errors++; $display("FAIL iv_result got mask=%b cnt=%0d want mask=1111 cnt=4", full_mask, full_count);
    end
`ifdef PIECE_COMMIT_SCORE_EN
    exp_score += 1200;
    checks++;
    if (score !== 16'(exp_score)) begin errors++; $display("FAIL iv_score got %0d want %0d", score, exp_score); end
`endif
  endtask

  task automatic test_start_while_busy();
    clear_board();
    pshape = 3'd3;
    px = '{0, 1, 0, 1}; py = '{0, 0, 1, 1};
    commit(10, 1'b1);
    checks++;
    if (done_cyc !== 47 || ndone !== 1) begin
      errors++; $display("FAIL busy_start_done got cycle=%0d count=%0d want 47 1", done_cyc, ndone);
    end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL busy_start_reaccept got busy_after=%b want 0", busy_after); end
    checks++;
    if (nwr !== 4 || wx[0] !== 0 || wy[0] !== 0 || wd[0] !== 4) begin
      errors++; $display("FAIL busy_start_writes got n=%0d x=%0d y=%0d d=%0d want 4 0 0 4", nwr, wx[0], wy[0], wd[0]);
    end
`ifdef PIECE_COMMIT_SCORE_EN
    @(negedge Clk); score_clr = 1'b1;
    @(negedge Clk); score_clr = 1'b0;
    exp_score = 0;
    checks++;
    if (score !== 16'd0) begin errors++; $display("FAIL score_clr got %0d want 0", score); end
`endif
  endtask

  task automatic test_reset_mid_scan();
    int ndone_r;
    clear_board();
    fill_row(20, 2, 3);
    pshape = 3'd5;
    px = '{2, 3, 2, 3}; py = '{20, 20, 21, 21};
    @(negedge Clk);
    drive_piece();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (14) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++;
    if ({busy, wr_en, done, wr_x, wr_y, wr_data, rd_x, rd_y, full_mask, full_count} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%b wr_en=%b done=%b rd=%0d/%0d mask=%b cnt=%0d want all 0",
               busy, wr_en, done, rd_x, rd_y, full_mask, full_count);
    end
    ndone_r = 0;
    repeat (60) begin @(negedge Clk); if (done) ndone_r++; end
    checks++;
    if (ndone_r !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", ndone_r); end
    checks++;
    if (board[21][3] !== 3'd6) begin errors++; $display("FAIL abort_partial_kept got %0d want 6", board[21][3]); end
    pshape = 3'd4;
    px = '{3, 4, 4, 5}; py = '{10, 10, 11, 11};
    commit(-1, 1'b0);
    checks++;
    if (done_cyc !== 47 || full_mask !== 4'b0000 || full_count !== 3'd0) begin
      errors++; $display("FAIL abort_fresh got cycle=%0d mask=%b cnt=%0d want 47 0000 0", done_cyc, full_mask, full_count);
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; clr = 1'b1; tb_we = 1'b0; tb_x = '0; tb_y = '0;
    pshape = '0; px = '{0, 0, 0, 0}; py = '{0, 0, 0, 0};
    drive_piece();
`ifdef PIECE_COMMIT_SCORE_EN
    score_clr = 1'b0; exp_score = 0;
`endif
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0; clr = 1'b0;
    @(negedge Clk);
    test_reset();
    test_o_empty();
    test_partial_row();
    test_i_horizontal();
    test_i_vertical();
    test_start_while_busy();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
